// File: rtl/piccolo_round_ctrl.sv
// piccolo_round_ctrl
//   Sequencer for the 3-rounds-per-step unrolled Piccolo encryption datapath
//   (80- or 128-bit key). Takes one plaintext block per in_valid/in_ready
//   handshake and latches the key-size select. While the block is in flight
//   it drives the datapath step enable and the round-number base. It then
//   holds ciphertext-valid until the consumer takes the block.
//
// Ports
//   clk, reset  rising-edge clock, synchronous active-high reset
//   in_valid    plaintext block + version available
//   in_ready    controller idle, can accept a block
//   version     0 = 80-bit key, 1 = 128-bit key, sampled on accept
//   dp_load     datapath load strobe (same cycle as the accept)
//   dp_step     datapath advances RPC rounds this cycle
//   round_num   round-number base for the first unrolled stage
//   ver_q       latched version, stable for the whole block
//   out_valid   datapath output is the final ciphertext
//   out_ready   consumer takes the ciphertext
//   busy        block in flight
//   blk_cnt     blocks delivered, wraps modulo 2^CNT_W
module piccolo_round_ctrl #(
  parameter int RPC        = 3,
  parameter int ROUNDS_80  = 25,
  parameter int ROUNDS_128 = 31,
  parameter int RN_W       = 5,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             version,
  output logic             dp_load,
  output logic             dp_step,
  output logic [RN_W-1:0]  round_num,
  output logic             ver_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam int N80   = (ROUNDS_80 - 1) / RPC;
  localparam int N128  = (ROUNDS_128 - 1) / RPC;
  localparam int NMAX  = (N80 > N128) ? N80 : N128;
  localparam int SC_W  = $clog2(NMAX + 1);

  // The step count only lands exactly on the last round when RPC divides it.
  if (((ROUNDS_80 - 1) % RPC) != 0) begin : g_bad_rounds_80
    $error("piccolo_round_ctrl: ROUNDS_80-1 must be divisible by RPC");
  end
  if (((ROUNDS_128 - 1) % RPC) != 0) begin : g_bad_rounds_128
    $error("piccolo_round_ctrl: ROUNDS_128-1 must be divisible by RPC");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SC_W-1:0]  step_cnt;

  // Value of the step counter during the final step of a block.
  function automatic logic [SC_W-1:0] last_step(input logic ver);
    last_step = ver ? SC_W'(N128 - 1) : SC_W'(N80 - 1);
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign dp_step   = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign dp_load   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (step_cnt == last_step(ver_q)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      round_num <= RN_W'(1);
      ver_q     <= 1'b0;
      blk_cnt   <= '0;
      step_cnt  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            ver_q     <= version;
            round_num <= RN_W'(1);
            step_cnt  <= '0;
          end
        end
        RUN: begin
          // After the final step round_num equals the last round number,
          // which the final-round stage consumes while in DONE.
          round_num <= round_num + RN_W'(RPC);
          step_cnt  <= step_cnt + SC_W'(1);
        end
        DONE: begin
          if (out_ready) blk_cnt <= blk_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piccolo_round_ctrl.sv
// tb_piccolo_round_ctrl
//   Directed bench for piccolo_round_ctrl. A second instance with a 4-bit
//   block counter shares all inputs so the counter wrap is reached with a
//   handful of blocks.
module tb_piccolo_round_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        version;
  logic        out_ready;

  logic        in_ready, dp_load, dp_step, ver_q, out_valid, busy;
  logic [4:0]  round_num;
  logic [15:0] blk_cnt;

  logic        w_in_ready, w_dp_load, w_dp_step, w_ver_q, w_out_valid, w_busy;
  logic [4:0]  w_round_num;
  logic [3:0]  w_blk_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  piccolo_round_ctrl u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .version   (version),
    .dp_load   (dp_load),
    .dp_step   (dp_step),
    .round_num (round_num),
    .ver_q     (ver_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .blk_cnt   (blk_cnt)
  );

  piccolo_round_ctrl #(.CNT_W(4)) u_wrap (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (w_in_ready),
    .version   (version),
    .dp_load   (w_dp_load),
    .dp_step   (w_dp_step),
    .round_num (w_round_num),
    .ver_q     (w_ver_q),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .busy      (w_busy),
    .blk_cnt   (w_blk_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete block: accept, N steps, optional DONE backpressure, drain.
  task automatic run_block(input logic ver, input int bp, input logic early_rdy);
    int n;
    int rounds;
    n      = ver ? 10 : 8;
    rounds = ver ? 31 : 25;

    in_valid = 1'b1;
    version  = ver;
    #1;
    check("accept_load",  32'(dp_load),  32'd1);
    check("accept_ready", 32'(in_ready), 32'd1);
    tick();
    // 128-bit blocks keep in_valid high while busy; it must be ignored.
    if (!ver) in_valid = 1'b0;
    if (early_rdy) out_ready = 1'b1;
    for (int k = 1; k <= n; k++) begin
      #1;
      check("run_step",  32'(dp_step), 32'd1);
      check("run_rn",    32'(round_num), 32'(1 + 3 * (k - 1)));
      check("run_flags", 32'({busy, in_ready, out_valid, dp_load}), 32'b1000);
      if (ver) version = ~version;
      tick();
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    #1;
    check("done_valid", 32'(out_valid), 32'd1);
    check("done_rn",    32'(round_num), 32'(rounds));
    check("done_ver",   32'(ver_q),     32'(ver));
    check("done_flags", 32'({dp_step, dp_load, in_ready, busy}), 32'b0001);
    for (int b = 0; b < bp; b++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_rn",    32'(round_num), 32'(rounds));
      check("bp_ready", 32'(in_ready),  32'd0);
      check("bp_cnt",   32'(blk_cnt),   32'(exp_cnt & 16'hFFFF));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt++;
    #1;
    check("idle_flags", 32'({in_ready, busy, out_valid, dp_step}), 32'b1000);
    check("idle_cnt",   32'(blk_cnt),   32'(exp_cnt & 16'hFFFF));
    check("idle_ver",   32'(ver_q),     32'(ver));
    check("wrap_cnt",   32'(w_blk_cnt), 32'(exp_cnt % 16));
    check("wrap_idle",
          32'({w_in_ready, w_dp_load, w_dp_step, w_out_valid, w_busy, w_ver_q, w_round_num}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ver, 5'(rounds)}));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    version   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_flags", 32'({in_ready, busy, out_valid, dp_step, dp_load}), 32'b10000);
    check("rst_rn",    32'(round_num), 32'd1);
    check("rst_cnt",   32'(blk_cnt),   32'd0);
    check("rst_ver",   32'(ver_q),     32'd0);

    // 80-bit block, then 128-bit with version toggling and early out_ready,
    // then 80-bit with five cycles of backpressure.
    run_block(1'b0, 0, 1'b0);
    run_block(1'b1, 0, 1'b1);
    run_block(1'b0, 5, 1'b0);

    // Reset in the middle of step 4 aborts the block.
    in_valid = 1'b1;
    version  = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("abort_rn_before", 32'(round_num), 32'd10);
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    exp_cnt = 0;
    check("abort_flags", 32'({in_ready, busy, out_valid, dp_step}), 32'b1000);
    check("abort_rn",    32'(round_num), 32'd1);
    check("abort_cnt",   32'(blk_cnt),   32'd0);
    tick();
    check("abort_no_valid", 32'(out_valid), 32'd0);
    run_block(1'b0, 0, 1'b0);

    // Deliver blocks until the 4-bit counter of the second instance wraps.
    while (exp_cnt < 16) run_block(1'b0, 0, 1'b0);
    check("wrap_zero", 32'(w_blk_cnt), 32'd0);
    check("cnt_16",    32'(blk_cnt),   32'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
